// File: rtl/piso_tx_pkg.sv
// piso_tx_pkg: shared state encoding and counter sizing for the serial transmitter
package piso_tx_pkg;
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/piso_tx_if.sv
// piso_tx_if: parallel word handshake plus serial line and frame status
interface piso_tx_if #(parameter int SIZE = 8);
   logic [SIZE-1:0] data_in;
   logic valid_in;
   logic ready_out;
   logic data_out;
   logic bit_strobe_out;
   logic busy_out;
   logic done_out;
   modport master (output data_in, valid_in, input ready_out, data_out, bit_strobe_out, busy_out, done_out);
   modport slave (input data_in, valid_in, output ready_out, data_out, bit_strobe_out, busy_out, done_out);
endinterface

// File: rtl/piso_tx_bit_timer.sv
// bit_timer: prescaler ticking once every DIV enabled clocks, restarted by clr
module bit_timer
   import piso_tx_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam int W = cnt_w(DIV);
   logic [W-1:0] cnt;
   assign tick = en && cnt == W'(DIV - 1);
   // count clocks inside the current bit period, wrapping at each tick
   always_ff @(posedge clk)
      if (rst || clr) cnt <= '0;
      else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, LSB first, DIV clocks per bit
module piso_tx
   import piso_tx_pkg::*;
#(
   parameter int   SIZE       = 8,
   parameter int   DIV        = 1,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input logic    clk_in,
   input logic    reset_in,
   piso_tx_if.slave bus
);
   localparam int CW = cnt_w(SIZE);
   state_t state, state_n;
   logic [SIZE-1:0] sr;
   logic [CW-1:0] cnt;
   logic tick, last, accept;
   bit_timer #(.DIV(DIV)) u_timer (
      .clk (clk_in),
      .rst (reset_in),
      .en  (state == SHIFT),
      .clr (accept),
      .tick(tick)
   );
   assign bus.busy_out = state == SHIFT;
   // handshake and next-state decode; ready opens in the final clock of the last bit
   always_comb begin
      last = state == SHIFT && tick && cnt == CW'(SIZE - 1);
      bus.ready_out = !reset_in && (state == IDLE || last);
      accept = bus.valid_in && bus.ready_out;
      state_n = accept ? SHIFT : last ? IDLE : state;
   end
   // state register
   always_ff @(posedge clk_in)
      state <= reset_in ? IDLE : state_n;
   // shift register, bit counter and registered serial outputs
   always_ff @(posedge clk_in)
      if (reset_in) begin
         sr                 <= '0;
         cnt                <= '0;
         bus.data_out       <= IDLE_LEVEL;
         bus.bit_strobe_out <= 1'b0;
         bus.done_out       <= 1'b0;
      end else if (accept) begin
         sr                 <= bus.data_in >> 1;
         cnt                <= '0;
         bus.data_out       <= bus.data_in[0];
         bus.bit_strobe_out <= 1'b1;
         bus.done_out       <= 1'b0;
      end else if (last) begin
         cnt                <= '0;
         bus.data_out       <= IDLE_LEVEL;
         bus.bit_strobe_out <= 1'b0;
         bus.done_out       <= 1'b1;
      end else if (tick) begin
         sr                 <= sr >> 1;
         cnt                <= cnt + 1'b1;
         bus.data_out       <= sr[0];
         bus.bit_strobe_out <= 1'b1;
         bus.done_out       <= 1'b0;
      end else begin
         bus.bit_strobe_out <= 1'b0;
         bus.done_out       <= 1'b0;
      end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: scoreboard bench for piso_tx at DIV=1 and DIV=3 with a sipo-style word collector
module tb_piso_tx;
   localparam int SIZE = 8;
   localparam logic IDLE = 1'b0;
   typedef struct {logic b; int n;} exp_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic [1:0] rst_v = 2'b11;
   logic [1:0] valid_v = 2'b00;
   logic [1:0][SIZE-1:0] data_v = '0;
   logic [1:0] ready_v, dout_v, stb_v, busy_v, done_v;
   int n = 0;
   int errs = 0;
   int checks = 0;
   int cur = 0;
   int div = 1;
   int free = 0;
   int done_at = 0;
   bit go = 1'b0;
   exp_t bq[$];
   logic [SIZE-1:0] wq[$];
   exp_t e;
   logic cur_bit = IDLE;
   logic [SIZE-1:0] sipo = '0;
   logic [SIZE-1:0] want;
   int scnt = 0;
   logic exp_stb, exp_busy;

   for (genvar g = 0; g < 2; g++) begin : u
      piso_tx_if #(.SIZE(SIZE)) bus ();
      piso_tx #(.SIZE(SIZE), .DIV(g == 0 ? 1 : 3), .IDLE_LEVEL(IDLE)) dut (
         .clk_in  (clk),
         .reset_in(rst_v[g]),
         .bus     (bus.slave)
      );
      assign bus.data_in  = data_v[g];
      assign bus.valid_in = valid_v[g];
      assign ready_v[g]   = bus.ready_out;
      assign dout_v[g]    = bus.data_out;
      assign stb_v[g]     = bus.bit_strobe_out;
      assign busy_v[g]    = bus.busy_out;
      assign done_v[g]    = bus.done_out;
   end

   always @(posedge clk) n <= n + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int want_v);
      checks++;
      if (act != want_v) begin
         errs++;
         $display("FAIL %s (div=%0d cycle=%0d): got %0d, expected %0d", nm, div, n, act, want_v);
      end
   endtask

   task automatic reset_cycles(input int k);
      rst_v[cur] = 1'b1;
      repeat (k) begin
         step();
         free = n;
         done_at = 0;
         bq.delete();
         wq.delete();
         go = 1'b1;
      end
      rst_v[cur] = 1'b0;
   endtask

   // model: a word is taken on the first edge at or after the line frees up;
   // its bits then appear every div cycles starting one cycle later
   task automatic send(input logic [SIZE-1:0] w, input int gap);
      repeat (gap) step();
      valid_v[cur] = 1'b1;
      forever begin
         data_v[cur] = (n + 1 >= free) ? w : SIZE'($urandom);
         step();
         if (n >= free) break;
      end
      for (int k = 0; k < SIZE; k++) bq.push_back('{w[k], n + k * div + 1});
      wq.push_back(w);
      free = n + SIZE * div;
      done_at = free + 1;
      valid_v[cur] = 1'b0;
      data_v[cur] = SIZE'($urandom);
   endtask

   // monitor: handshake/status against the model, serial bits popped on each strobe
   always @(negedge clk) if (go) begin
      exp_busy = n + 1 <= free;
      chk("ready", ready_v[cur], !rst_v[cur] && n + 1 >= free);
      chk("busy", busy_v[cur], exp_busy);
      chk("done", done_v[cur], n + 1 == done_at);
      exp_stb = bq.size() != 0 && bq[0].n == n + 1;
      chk("strobe", stb_v[cur], exp_stb);
      if (stb_v[cur] && bq.size() != 0) begin
         e = bq.pop_front();
         chk("bit", dout_v[cur], e.b);
         cur_bit = e.b;
         sipo = {dout_v[cur], sipo[SIZE-1:1]};
         scnt++;
         if (scnt == SIZE) begin
            want = wq.size() != 0 ? wq.pop_front() : ~sipo;
            chk("sipo_word", sipo, want);
            scnt = 0;
         end
      end else begin
         if (exp_stb) begin
            e = bq.pop_front();
            cur_bit = e.b;
         end
         chk("line", dout_v[cur], exp_busy ? cur_bit : IDLE);
      end
      if (rst_v[cur]) scnt = 0;
   end

   initial begin
      for (int g = 0; g < 2; g++) begin
         go = 1'b0;
         cur = g;
         div = g == 0 ? 1 : 3;
         reset_cycles(2);
         send(8'hCD, 0);
         send(8'hCD, 30);
         send(8'hAB, 0);
         send(8'h01, 30);
         send(8'hCD, 30);
         send(8'h55, 2);
         send(8'hFF, 30);
         repeat (4 * div + 1) step();
         reset_cycles(1);
         send(8'h0F, 0);
         repeat (40) send(SIZE'($urandom), ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 12 * div)));
         repeat (12 * div) step();
         go = 1'b0;
         rst_v[g] = 1'b1;
      end
      step();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter SIZE, default 8, frame width in bits; SHALL be >= 2.
REQ-002 Parameter DIV, default 1, clocks per serial bit; SHALL be >= 1.
REQ-003 Parameter IDLE_LEVEL, default 1'b0, serial line level when no frame is in flight.
REQ-004 clk_in  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset_in  input  1  reset, synchronous and active-high.
REQ-006 data_in  input  SIZE  parallel word to transmit.
REQ-007 valid_in  input  1  data_in holds a word to send.
REQ-008 ready_out  output  1  block accepts a word this cycle.
REQ-009 data_out  output  1  serial bit stream, registered, LSB first.
REQ-010 bit_strobe_out  output  1  one-cycle pulse in the cycle data_out presents a new bit.
REQ-011 busy_out  output  1  frame in flight.
REQ-012 done_out  output  1  one-cycle pulse after the final bit period of a frame ends.

Function
REQ-013 A word SHALL be accepted on any rising edge where valid_in && ready_out; data_in SHALL be captured into an internal shift register on that edge.
REQ-014 States SHALL be IDLE and SHIFT; IDLE->SHIFT on accept; SHIFT->IDLE after the last bit period with no accept; SHIFT->SHIFT on a back-to-back accept.
REQ-015 ready_out SHALL be 1 in IDLE and in the final clock of the final bit period in SHIFT; 0 otherwise.
REQ-016 Latency: data_out SHALL show bit 0 of the accepted word in the cycle after accept, with bit_strobe_out = 1 in that cycle.
REQ-017 Each bit SHALL be held for exactly DIV cycles; bit k SHALL appear k*DIV cycles after bit 0, k = 0..SIZE-1.
REQ-018 Bit counter SHALL be $clog2(SIZE) bits wide; divider counter $clog2(DIV) bits wide (1 bit minimum when DIV = 1); neither SHALL wrap mid-frame.
REQ-019 Back-to-back accept: bit 0 of the new word SHALL follow bit SIZE-1 of the old word with no gap cycle; busy_out SHALL stay 1, and done_out SHALL NOT pulse between the two frames.
REQ-020 done_out SHALL pulse for one cycle in the first cycle after a frame's final bit period when no back-to-back accept occurred; busy_out SHALL be 0 in that same cycle.
REQ-021 In IDLE, data_out SHALL equal IDLE_LEVEL and bit_strobe_out SHALL be 0.
REQ-022 While ready_out = 0, valid_in and data_in SHALL be ignored; the in-flight frame SHALL be unaffected.

Reset
REQ-023 With reset_in = 1 on a rising edge, the state SHALL go to IDLE and the following SHALL be set: data_out = IDLE_LEVEL, bit_strobe_out = 0, busy_out = 0, done_out = 0, counters = 0, shift register = 0.
REQ-024 ready_out SHALL be 0 while reset_in = 1, and 1 in the first cycle after release.
REQ-025 Reset asserted mid-frame SHALL abort the frame, with no done_out pulse; no residual bits SHALL be sent after release.

Structure
REQ-026 A shared package piso_tx_pkg SHALL hold the state encoding (IDLE = 0, SHIFT = 1) and the counter-width function used for $clog2 sizing.
REQ-027 The DIV prescaler SHALL be the sub-module bit_timer, which emits a one-cycle tick every DIV cycles while enabled and reloads on its clear input.
REQ-028 The shift register, bit counter and FSM SHALL live in piso_tx.

Verification
REQ-029 SIZE=8, DIV=1, send 8'hCD -> data_out = 1,0,1,1,0,0,1,1 on cycles 1..8 after accept, with 8 strobes; done_out pulses at cycle 9.
REQ-030 Send 8'hCD then 8'hAB with valid_in held high -> 16 contiguous bits 1,0,1,1,0,0,1,1,1,1,0,1,0,1,0,1; busy_out stays high; exactly one done_out pulse.
REQ-031 DIV=3, send 8'h01 -> data_out = 1 for 3 cycles then 0 for 21 cycles; strobes 3 cycles apart.
REQ-032 Assert reset_in at bit 4 of 8'hFF -> next cycle data_out = IDLE_LEVEL, busy_out = 0, no done_out; a following 8'h0F frame is sent intact.
REQ-033 Drive valid_in with 8'h55 while busy sending 8'hCD -> 8'h55 is not sent until ready_out is asserted.
REQ-034 Loop data_out into the team's sipo with SIZE=8, clocked by the same clock and enabled on bit_strobe_out; send 16'hABCD as two words -> sipo output reads 8'hCD, then 8'hAB.
